// File: rtl/route_cmd_proc_pkg.sv
// Shared types for the route command processor: opcodes, FSM states, ID tag.
package route_pkg;

    typedef enum logic [1:0] {
        OP_STOP   = 2'b00,
        OP_GO     = 2'b01,
        OP_ADD    = 2'b10,
        OP_RESUME = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MOVE  = 2'b01,
        DWELL = 2'b10
    } state_t;

    // Upper two bits of a station ID word must carry this tag for the ID to be usable.
    localparam logic [1:0] ID_VALID_TAG = 2'b00;

endpackage

// File: rtl/route_cmd_proc_dest_fifo.sv
// Destination queue: synchronous FIFO with flush, simultaneous push/pop, count and head.
// A flush combined with a push leaves exactly the pushed entry in the queue.
module dest_fifo #(
    parameter int ID_W  = 6,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [ID_W-1:0]        din,
    output logic [ID_W-1:0]        head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ID_W-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    // A pop in the same cycle frees a slot, so a push onto a full queue still lands.
    assign do_push = push & (~full | do_pop | flush);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? AW'(1) : '0;
            count  <= do_push ? CW'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[flush ? '0 : wr_ptr] <= din;
    end

endmodule

// File: rtl/route_cmd_proc.sv
// Route command processor: consumes route commands and station IDs, sequences
// motion through queued destinations with dwell stops, and drives the blocked-path buzzer.
//
//  state | meaning
//  IDLE  | no active route; IDs ignored, RESUME may restart a queued route
//  MOVE  | heading to queue head; go follows Ok2Move, buzzer active when blocked
//  DWELL | stopped at an intermediate station for DWELL_CYC cycles
module route_cmd_proc
    import route_pkg::*;
#(
    parameter int ID_W      = 6,
    parameter int DEPTH     = 4,
    parameter int DWELL_CYC = 50000,
    parameter int BUZZ_HALF = 12500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_rdy,
    input  logic [ID_W+1:0]        cmd,
    output logic                   clr_cmd_rdy,
    input  logic                   ID_vld,
    input  logic [ID_W+1:0]        ID,
    output logic                   clr_ID_vld,
    input  logic                   Ok2Move,
    output logic                   go,
    output logic                   in_transit,
    output logic                   buzz,
    output logic                   buzz_n,
    output logic                   arrived,
    output logic [$clog2(DEPTH):0] q_cnt,
    output logic                   err_ovf
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(DWELL_CYC) + 1;
    localparam int BW = $clog2(BUZZ_HALF) + 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYC - 1);
    localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_HALF - 1);

    state_t          state;
    logic [DW-1:0]   dwell_cnt;
    logic [BW-1:0]   buzz_cnt;
    opcode_t         op;
    logic            cmd_acc;
    logic            id_acc;
    logic            cmd_stop;
    logic            cmd_go;
    logic            cmd_add;
    logic            cmd_resume;
    logic            id_match;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] head;
    logic            add_drop;
    logic            q_left;
    logic            buzz_en;

    // A request is taken only when its clear pulse is not already pending.
    assign cmd_acc    = cmd_rdy & ~clr_cmd_rdy;
    assign id_acc     = ID_vld & ~clr_ID_vld;
    assign op         = opcode_t'(cmd[ID_W+1:ID_W]);
    assign cmd_stop   = cmd_acc & (op == OP_STOP);
    assign cmd_go     = cmd_acc & (op == OP_GO);
    assign cmd_add    = cmd_acc & (op == OP_ADD);
    assign cmd_resume = cmd_acc & (op == OP_RESUME);

    // STOP and GO override any ID arriving in the same cycle.
    assign fifo_flush = cmd_stop | cmd_go;
    assign id_match   = id_acc & ~fifo_flush & (state == MOVE) & ~fifo_empty &
                        (ID[ID_W+1:ID_W] == ID_VALID_TAG) & (ID[ID_W-1:0] == head);
    assign fifo_pop   = id_match;
    assign fifo_push  = cmd_go | (cmd_add & (~fifo_full | id_match));
    assign add_drop   = cmd_add & fifo_full & ~id_match;
    assign q_left     = (q_cnt > CW'(1)) | fifo_push;

    assign in_transit = (state != IDLE);
    assign go         = (state == MOVE) & Ok2Move;
    assign buzz_en    = (state == MOVE) & ~Ok2Move;
    assign buzz_n     = ~buzz;

    dest_fifo #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (cmd[ID_W-1:0]),
        .head  (head),
        .count (q_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Consume pulses for the command and ID receivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cmd_rdy <= 1'b0;
            clr_ID_vld  <= 1'b0;
        end else begin
            clr_cmd_rdy <= cmd_acc;
            clr_ID_vld  <= id_acc;
        end
    end

    // Route FSM with dwell timer, overflow flag and arrival pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            err_ovf   <= 1'b0;
            arrived   <= 1'b0;
        end else begin
            arrived <= 1'b0;
            if (cmd_stop) begin
                state   <= IDLE;
                err_ovf <= 1'b0;
            end else if (cmd_go) begin
                state   <= MOVE;
                err_ovf <= 1'b0;
            end else begin
                if (add_drop) err_ovf <= 1'b1;
                case (state)
                    IDLE: begin
                        if (cmd_resume && !fifo_empty) state <= MOVE;
                    end
                    MOVE: begin
                        if (id_match) begin
                            if (q_left) begin
                                state     <= DWELL;
                                dwell_cnt <= DWELL_LOAD;
                            end else begin
                                state   <= IDLE;
                                arrived <= 1'b1;
                            end
                        end
                    end
                    DWELL: begin
                        if (dwell_cnt == '0) state <= MOVE;
                        else                 dwell_cnt <= dwell_cnt - DW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Buzzer square wave, held at zero whenever the path is not blocked in MOVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzz_cnt <= '0;
            buzz     <= 1'b0;
        end else if (!buzz_en) begin
            buzz_cnt <= '0;
            buzz     <= 1'b0;
        end else if (buzz_cnt == BUZZ_LAST) begin
            buzz_cnt <= '0;
            buzz     <= ~buzz;
        end else begin
            buzz_cnt <= buzz_cnt + BW'(1);
        end
    end

endmodule

// File: tb/tb_route_cmd_proc.sv
// Scoreboard bench for route_cmd_proc: a queue-based route model predicts the
// state after every accepted command/ID; a monitor checks it on each consume pulse.
module tb_route_cmd_proc;

    localparam int ID_W  = 6;
    localparam int DEPTH = 4;
    localparam int DWELL = 20;
    localparam int BH    = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_rdy, ID_vld, Ok2Move;
    logic [7:0] cmd, ID;
    logic       clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n, arrived, err_ovf;
    logic [2:0] q_cnt;

    route_cmd_proc #(.ID_W(ID_W), .DEPTH(DEPTH), .DWELL_CYC(DWELL), .BUZZ_HALF(BH)) dut (
        .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .clr_cmd_rdy(clr_cmd_rdy),
        .ID_vld(ID_vld), .ID(ID), .clr_ID_vld(clr_ID_vld), .Ok2Move(Ok2Move), .go(go),
        .in_transit(in_transit), .buzz(buzz), .buzz_n(buzz_n), .arrived(arrived),
        .q_cnt(q_cnt), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit c;
        bit i;
        int qc;
        bit err;
        bit it;
        bit arr;
    } exp_t;
    exp_t sb[$];

    // Route model: list of pending stations plus moving/dwelling flags.
    int          mq[$];
    bit          m_move, m_dwell, m_err;
    int unsigned m_dwell_end;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_move  = 0;
        m_dwell = 0;
        m_err   = 0;
    endtask

    // e = index of the clock edge on which the DUT accepts this request.
    task automatic model_step(input int unsigned e, input bit dc, input logic [7:0] c,
                              input bit di, input logic [7:0] i);
        exp_t x;
        bit   match = 0;
        bit   arr   = 0;
        int   op    = int'(c[7:6]);
        if (m_dwell && e > m_dwell_end) begin
            m_dwell = 0;
            m_move  = 1;
        end
        if (dc && op == 0) begin
            mq.delete(); m_move = 0; m_dwell = 0; m_err = 0;
        end else if (dc && op == 1) begin
            mq.delete(); mq.push_back(int'(c[5:0])); m_move = 1; m_dwell = 0; m_err = 0;
        end else begin
            match = di && m_move && (i[7:6] == 2'b00) && (mq.size() > 0) && (int'(i[5:0]) == mq[0]);
            if (match) void'(mq.pop_front());
            if (dc && op == 2) begin
                if (mq.size() < DEPTH) mq.push_back(int'(c[5:0]));
                else m_err = 1;
            end
            if (dc && op == 3 && !m_move && !m_dwell && mq.size() > 0) m_move = 1;
            if (match) begin
                m_move = 0;
                if (mq.size() > 0) begin
                    m_dwell     = 1;
                    m_dwell_end = e + DWELL;
                end else begin
                    arr = 1;
                end
            end
        end
        x.c = dc; x.i = di; x.qc = mq.size(); x.err = m_err; x.it = m_move | m_dwell; x.arr = arr;
        sb.push_back(x);
    endtask

    task automatic drive(input bit dc, input logic [7:0] c, input bit di, input logic [7:0] i,
                         input int hold = 1);
        @(negedge clk);
        cmd_rdy = dc; cmd = c; ID_vld = di; ID = i;
        if (dc || di) model_step(cyc + 1, dc, c, di, i);
        repeat (hold) @(negedge clk);
        cmd_rdy = 0; ID_vld = 0;
    endtask

    task automatic measure_dwell();
        int n = 0;
        while (go == 1'b0 && n < 4 * DWELL) begin
            n++;
            @(negedge clk);
        end
        chk("dwell_len_cycles", n, DWELL);
        chk("go_after_dwell", go, 1);
    endtask

    // Monitor: each consume pulse marks one accepted request; compare against the model.
    always @(negedge clk) begin
        exp_t x;
        if (!rst && (clr_cmd_rdy || clr_ID_vld)) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_consume: clr_cmd_rdy=%0b clr_ID_vld=%0b, expected no pulse", clr_cmd_rdy, clr_ID_vld);
            end else begin
                x = sb.pop_front();
                chk("sb_clr_cmd_rdy", clr_cmd_rdy, x.c);
                chk("sb_clr_ID_vld", clr_ID_vld, x.i);
                chk("sb_q_cnt", q_cnt, x.qc);
                chk("sb_err_ovf", err_ovf, x.err);
                chk("sb_in_transit", in_transit, x.it);
                chk("sb_arrived", arrived, x.arr);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int prev, last, ntog;
        bit dc, di;
        logic [7:0] c, i;
        rst = 1; cmd_rdy = 0; ID_vld = 0; cmd = 0; ID = 0; Ok2Move = 1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_go", go, 0);
        chk("rst_in_transit", in_transit, 0);
        chk("rst_buzz", buzz, 0);
        chk("rst_buzz_n", buzz_n, 1);
        chk("rst_arrived", arrived, 0);
        chk("rst_q_cnt", q_cnt, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_clr_cmd_rdy", clr_cmd_rdy, 0);
        chk("rst_clr_ID_vld", clr_ID_vld, 0);
        rst = 0;

        // Single-stop route.
        drive(1, 8'h45, 0, 8'h00);
        chk("go_in_move", go, 1);
        drive(0, 8'h00, 1, 8'h05);
        chk("go_after_arrive", go, 0);
        @(negedge clk);
        chk("arrived_one_cycle", arrived, 0);

        // Three stops with two dwells.
        drive(1, 8'h41, 0, 8'h00);
        drive(1, 8'h82, 0, 8'h00);
        drive(1, 8'h83, 0, 8'h00);
        drive(0, 8'h00, 1, 8'h01);
        measure_dwell();
        drive(0, 8'h00, 1, 8'h02);
        measure_dwell();
        drive(0, 8'h00, 1, 8'h03);

        // Overflow, ADD+pop on full, STOP clears.
        drive(1, 8'h00, 0, 8'h00);
        drive(1, 8'h4A, 0, 8'h00);
        drive(1, 8'h8B, 0, 8'h00);
        drive(1, 8'h8C, 0, 8'h00);
        drive(1, 8'h8D, 0, 8'h00);
        drive(1, 8'h8E, 0, 8'h00);
        chk("ovf_q_cnt", q_cnt, DEPTH);
        chk("ovf_flag", err_ovf, 1);
        drive(1, 8'h94, 1, 8'h0A);
        drive(1, 8'h00, 0, 8'h00);
        chk("stop_err_clear", err_ovf, 0);

        // Buzzer while blocked in MOVE.
        drive(1, 8'h47, 0, 8'h00);
        Ok2Move = 0;
        prev = 0; last = 0; ntog = 0;
        for (int s = 1; s <= 6 * BH && ntog < 3; s++) begin
            @(negedge clk);
            chk("buzz_n_complement", buzz_n, ~buzz & 1'b1);
            if (int'(buzz) != prev) begin
                chk("buzz_half_period", s - last, BH);
                chk("go_while_blocked", go, 0);
                last = s; prev = int'(buzz); ntog++;
            end
        end
        chk("buzz_toggle_count", ntog, 3);
        Ok2Move = 1;
        @(negedge clk);
        chk("buzz_off_when_clear", buzz, 0);
        chk("buzz_n_off_when_clear", buzz_n, 1);
        chk("go_when_clear", go, 1);

        // Invalid tag, wrong station, GO racing an ID.
        drive(0, 8'h00, 1, 8'h47);
        drive(0, 8'h00, 1, 8'h45);
        drive(0, 8'h00, 1, 8'h08);
        drive(1, 8'h49, 1, 8'h07);
        drive(0, 8'h00, 1, 8'h09);

        // ADD in IDLE, RESUME, RESUME on empty, held cmd_rdy accepted once.
        drive(1, 8'h83, 0, 8'h00);
        drive(1, 8'hC0, 0, 8'h00);
        drive(0, 8'h00, 1, 8'h03);
        drive(1, 8'hC0, 0, 8'h00);
        drive(1, 8'h84, 0, 8'h00, 2);
        drive(1, 8'h00, 0, 8'h00);

        // Reset in the middle of a dwell.
        drive(1, 8'h41, 0, 8'h00);
        drive(1, 8'h82, 0, 8'h00);
        drive(0, 8'h00, 1, 8'h01);
        repeat (5) @(negedge clk);
        #1 rst = 1;
        #1;
        chk("midrst_in_transit", in_transit, 0);
        chk("midrst_go", go, 0);
        chk("midrst_q_cnt", q_cnt, 0);
        chk("midrst_buzz_n", buzz_n, 1);
        model_reset();
        @(negedge clk);
        rst = 0;
        drive(1, 8'hC0, 0, 8'h00);

        // Randomized traffic.
        for (int k = 0; k < 250; k++) begin
            int r = $urandom_range(0, 9);
            int w = $urandom_range(0, 19);
            dc = (r < 6);
            di = (r >= 4);
            if (w < 2)       c = {2'b00, 6'($urandom_range(0, 7))};
            else if (w < 6)  c = {2'b01, 6'($urandom_range(0, 7))};
            else if (w < 15) c = {2'b10, 6'($urandom_range(0, 7))};
            else             c = {2'b11, 6'($urandom_range(0, 7))};
            if (mq.size() > 0 && $urandom_range(0, 9) < 6) i = {2'b00, 6'(mq[0])};
            else i = 8'($urandom_range(0, 255));
            if (r == 9 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, DWELL + 4)) @(negedge clk);
            end else begin
                drive(dc, c, di, i);
            end
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
